lime_out_port: RTL and testbench

//  Output-port stage directly downstream of the Lime 16-bit multi-cycle processor core.

---
 rtl/lime_io_pkg.sv | 25 ++
 rtl/lime_fifo_ctrl.sv | 82 ++++++++
 rtl/lime_out_port.sv | 135 +++++++++++++
 tb/tb_lime_out_port.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lime_io_pkg.sv
// -----------------------------------------------------------------------------
// lime_io_pkg
// Shared definitions for the Lime 16-bit core output path. The core, the
// output-port stage and the bench all import this package so that the word
// width and buffer depth are defined in exactly one place.
//   LIME_DATA_W    : width of a processor output word
//   LIME_OUT_DEPTH : number of entries in the output-port FIFO (power of two)
//   clog2()        : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package lime_io_pkg;

  localparam int LIME_DATA_W    = 32'sd16;
  localparam int LIME_OUT_DEPTH = 32'sd4;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lime_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// lime_fifo_ctrl
// Pointer / occupancy controller for the Lime output-port FIFO. Qualifies the
// raw write strobe and host handshake into push/pop and keeps the read and
// write pointers and the occupancy count. Storage lives in the parent.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   out_we       : core write strobe (raw, before qualification)
//   host_ready   : host accepts the head entry this cycle
//   push, pop    : qualified FIFO operations for this cycle
//   wr_ptr       : tail index (next slot to write)
//   rd_ptr       : head index
//   count        : occupancy 0..DEPTH
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module lime_fifo_ctrl
  import lime_io_pkg::*;
#(
  parameter  int DEPTH = LIME_OUT_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          out_we,
  input  logic          host_ready,
  output logic          push,
  output logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;

  assign full_s  = (count_r == (AW+1)'(DEPTH));
  assign empty_s = (count_r == (AW+1)'(0));
  assign pop_s   = ~empty_s & host_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_s  = out_we & (~full_s | pop_s);

  // Pointer and occupancy state; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign push   = push_s;
  assign pop    = pop_s;
  assign wr_ptr = wr_ptr_r;
  assign rd_ptr = rd_ptr_r;
  assign count  = count_r;
  assign full   = full_s;
  assign empty  = empty_s;

endmodule

// File: rtl/lime_out_port.sv
// -----------------------------------------------------------------------------
// lime_out_port
// Output-port stage behind the Lime core. Every core output write is mirrored
// in last_out and buffered in a small FIFO that a host drains over a
// valid/ready handshake.
// Build option: LIME_OUT_STALL_EN
//   undefined : writes arriving while full (and not popping) are dropped and
//               the sticky ovf flag is raised; cpu_stall does not exist.
//   defined   : cpu_stall back-pressures the core instead; nothing is dropped
//               and ovf is tied low.
// Ports:
//   CLK, RST_N  : clock, asynchronous active-low reset
//   out_we      : core output-write strobe
//   out_data    : core output value, sampled when out_we=1
//   last_out    : most recent value written by the core
//   host_valid  : FIFO head valid
//   host_data   : FIFO head word (0 when empty)
//   host_ready  : host accepts head this cycle
//   count       : occupancy 0..DEPTH
//   full        : count == DEPTH
//   ovf         : sticky overflow flag
//   ovf_clr     : clears ovf (a coincident overflow wins)
//   cpu_stall   : stall request to the core (LIME_OUT_STALL_EN only)
// -----------------------------------------------------------------------------
module lime_out_port
  import lime_io_pkg::*;
#(
  parameter  int DATA_W = LIME_DATA_W,
  parameter  int DEPTH  = LIME_OUT_DEPTH,
  localparam int AW     = clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              out_we,
  input  logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] last_out,
  output logic              host_valid,
  output logic [DATA_W-1:0] host_data,
  input  logic              host_ready,
  output logic [AW:0]       count,
  output logic              full,
  output logic              ovf,
  input  logic              ovf_clr
`ifdef LIME_OUT_STALL_EN
  ,
  output logic              cpu_stall
`endif
);

  logic              push_s;
  logic              pop_s;
  logic [AW-1:0]     wr_ptr_s;
  logic [AW-1:0]     rd_ptr_s;
  logic [AW:0]       count_s;
  logic              full_s;
  logic              empty_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] last_out_r;

  lime_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_fifo_ctrl (
    .clk        (CLK),
    .rst_n      (RST_N),
    .out_we     (out_we),
    .host_ready (host_ready),
    .push       (push_s),
    .pop        (pop_s),
    .wr_ptr     (wr_ptr_s),
    .rd_ptr     (rd_ptr_s),
    .count      (count_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  // FIFO storage; the tail slot is written on each qualified push.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_s] <= out_data;
    end else begin
      mem_r[wr_ptr_s] <= mem_r[wr_ptr_s];
    end
  end

  // Mirror of the core's latest output, including writes the FIFO rejected.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_out_r <= {DATA_W{1'b0}};
    end else if (out_we) begin
      last_out_r <= out_data;
    end else begin
      last_out_r <= last_out_r;
    end
  end

`ifdef LIME_OUT_STALL_EN
  // Back-pressure replaces dropping, so the overflow flag can never fire.
  logic unused_ovf_clr_s;
  assign unused_ovf_clr_s = ovf_clr;
  assign cpu_stall        = full_s & ~pop_s;
  assign ovf              = 1'b0;
`else
  logic overflow_s;
  logic ovf_r;

  assign overflow_s = out_we & full_s & ~pop_s;

  // Sticky overflow flag; a new overflow takes priority over a clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_r <= 1'b0;
    end else if (overflow_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  assign last_out   = last_out_r;
  assign host_valid = ~empty_s;
  // Head is forced to zero when empty so stale storage never leaks out.
  assign host_data  = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_s];
  assign count      = count_s;
  assign full       = full_s;

endmodule

// File: tb/tb_lime_out_port.sv
// -----------------------------------------------------------------------------
// tb_lime_out_port
// Self-checking bench for lime_out_port. A vector table supplies per-cycle
// inputs with the expected count, last_out and ovf after the edge; written
// words are queued in a scoreboard and compared as the host pops them.
// Build with or without LIME_OUT_STALL_EN.
// -----------------------------------------------------------------------------
module tb_lime_out_port;
  import lime_io_pkg::*;

  localparam int DW      = LIME_DATA_W;
  localparam int DEPTH   = LIME_OUT_DEPTH;
  localparam int AW      = clog2(DEPTH);
  localparam int RST_ROW = 19;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
    logic          ready;
    logic          clr;
    int            exp_count;
    logic [DW-1:0] exp_last;
    logic          exp_ovf;
  } vec_t;

  logic          CLK;
  logic          RST_N;
  logic          out_we;
  logic [DW-1:0] out_data;
  logic [DW-1:0] last_out;
  logic          host_valid;
  logic [DW-1:0] host_data;
  logic          host_ready;
  logic [AW:0]   count;
  logic          full;
  logic          ovf;
  logic          ovf_clr;
`ifdef LIME_OUT_STALL_EN
  logic          cpu_stall;
`endif

  int            checks;
  int            errors;
  int            cur_count;
  logic [DW-1:0] sb [$];
  vec_t          vecs [$];

  lime_out_port dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .out_we     (out_we),
    .out_data   (out_data),
    .last_out   (last_out),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .count      (count),
    .full       (full),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
`ifdef LIME_OUT_STALL_EN
    ,
    .cpu_stall  (cpu_stall)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [DW-1:0] d, input logic rdy,
                              input logic clr, input int cnt, input logic [DW-1:0] last,
                              input logic o);
    vec_t v;
    v.we = we; v.data = d; v.ready = rdy; v.clr = clr;
    v.exp_count = cnt; v.exp_last = last; v.exp_ovf = o;
    return v;
  endfunction

  // One clock cycle: drive at negedge, check handshake before the edge, state after it.
  task automatic cycle(input vec_t v);
    logic          pre_valid;
    logic          do_pop;
    logic [DW-1:0] e;
    @(negedge CLK);
    out_we = v.we; out_data = v.data; host_ready = v.ready; ovf_clr = v.clr;
    #1;
    pre_valid = (cur_count != 0);
    chk("valid_pre", {31'd0, host_valid}, {31'd0, pre_valid});
    do_pop = pre_valid && v.ready;
    if (do_pop) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow actual=pop expected=none");
      end else begin
        e = sb.pop_front();
        chk("head_pop", {16'd0, host_data}, {16'd0, e});
      end
    end else if (pre_valid && sb.size() > 0) begin
      chk("head_hold", {16'd0, host_data}, {16'd0, sb[0]});
    end
`ifdef LIME_OUT_STALL_EN
    chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, (cur_count == DEPTH) && !do_pop});
`endif
    if (v.we && (cur_count < DEPTH || do_pop)) sb.push_back(v.data);
    @(posedge CLK);
    #1;
    chk("count", 32'(count), 32'(v.exp_count));
    chk("full", {31'd0, full}, {31'd0, v.exp_count == DEPTH});
    chk("valid_post", {31'd0, host_valid}, {31'd0, v.exp_count != 0});
    chk("last_out", {16'd0, last_out}, {16'd0, v.exp_last});
    chk("ovf", {31'd0, ovf}, {31'd0, v.exp_ovf});
    cur_count = v.exp_count;
  endtask

  initial begin
    checks = 0; errors = 0; cur_count = 0;
    RST_N = 1'b0; out_we = 1'b0; out_data = 16'h0000; host_ready = 1'b0; ovf_clr = 1'b0;

    // Single write and pop
    vecs.push_back(mk(1'b1, 16'h0005, 1'b0, 1'b0, 1, 16'h0005, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0005, 1'b0));
    // Fill, partial drain, refill across the pointer wrap
    vecs.push_back(mk(1'b1, 16'h0001, 1'b0, 1'b0, 1, 16'h0001, 1'b0));
    vecs.push_back(mk(1'b1, 16'h0002, 1'b0, 1'b0, 2, 16'h0002, 1'b0));
    vecs.push_back(mk(1'b1, 16'h0003, 1'b0, 1'b0, 3, 16'h0003, 1'b0));
    vecs.push_back(mk(1'b1, 16'h0004, 1'b0, 1'b0, 4, 16'h0004, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 3, 16'h0004, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 2, 16'h0004, 1'b0));
    vecs.push_back(mk(1'b1, 16'h0005, 1'b0, 1'b0, 3, 16'h0005, 1'b0));
    vecs.push_back(mk(1'b1, 16'h0006, 1'b0, 1'b0, 4, 16'h0006, 1'b0));
    // Push and pop together while full
    vecs.push_back(mk(1'b1, 16'h0BEE, 1'b1, 1'b0, 4, 16'h0BEE, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 3, 16'h0BEE, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 2, 16'h0BEE, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h0BEE, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0BEE, 1'b0));
    // Ready on empty is a no-op
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0BEE, 1'b0));
    // Build up three words before the async reset
    vecs.push_back(mk(1'b1, 16'h1234, 1'b0, 1'b0, 1, 16'h1234, 1'b0));
    vecs.push_back(mk(1'b1, 16'h2222, 1'b0, 1'b0, 2, 16'h2222, 1'b0));
    vecs.push_back(mk(1'b1, 16'h3333, 1'b0, 1'b0, 3, 16'h3333, 1'b0));
    // After reset: old words gone, new word flows
    vecs.push_back(mk(1'b1, 16'h4444, 1'b0, 1'b0, 1, 16'h4444, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h4444, 1'b0));

    // Power-on reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", {31'd0, host_valid}, 32'd0);
    chk("rst_data", {16'd0, host_data}, 32'd0);
    chk("rst_last", {16'd0, last_out}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == RST_ROW) begin
        // Reset asserted between edges must clear state without a clock
        @(negedge CLK);
        out_we = 1'b0; host_ready = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", {31'd0, host_valid}, 32'd0);
        chk("arst_last", {16'd0, last_out}, 32'd0);
        chk("arst_data", {16'd0, host_data}, 32'd0);
        chk("arst_full", {31'd0, full}, 32'd0);
        sb.delete();
        cur_count = 0;
        #1 RST_N = 1'b1;
      end
      cycle(vecs[i]);
    end

`ifdef LIME_OUT_STALL_EN
    // Full with host stalled: core is held, then accepted once the host pops
    cycle(mk(1'b1, 16'h0011, 1'b0, 1'b0, 1, 16'h0011, 1'b0));
    cycle(mk(1'b1, 16'h0022, 1'b0, 1'b0, 2, 16'h0022, 1'b0));
    cycle(mk(1'b1, 16'h0033, 1'b0, 1'b0, 3, 16'h0033, 1'b0));
    cycle(mk(1'b1, 16'h0044, 1'b0, 1'b0, 4, 16'h0044, 1'b0));
    cycle(mk(1'b1, 16'h0777, 1'b0, 1'b0, 4, 16'h0777, 1'b0));
    cycle(mk(1'b1, 16'h0777, 1'b1, 1'b0, 4, 16'h0777, 1'b0));
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b0, 3, 16'h0777, 1'b0));
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b0, 2, 16'h0777, 1'b0));
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h0777, 1'b0));
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0777, 1'b0));
`else
    // Overflow drops the word, clear works, set wins over a coincident clear
    cycle(mk(1'b1, 16'h0011, 1'b0, 1'b0, 1, 16'h0011, 1'b0));
    cycle(mk(1'b1, 16'h0022, 1'b0, 1'b0, 2, 16'h0022, 1'b0));
    cycle(mk(1'b1, 16'h0033, 1'b0, 1'b0, 3, 16'h0033, 1'b0));
    cycle(mk(1'b1, 16'h0044, 1'b0, 1'b0, 4, 16'h0044, 1'b0));
    cycle(mk(1'b1, 16'h00AA, 1'b0, 1'b0, 4, 16'h00AA, 1'b1));
    cycle(mk(1'b0, 16'h0000, 1'b0, 1'b1, 4, 16'h00AA, 1'b0));
    cycle(mk(1'b1, 16'h00BB, 1'b0, 1'b1, 4, 16'h00BB, 1'b1));
    cycle(mk(1'b0, 16'h0000, 1'b0, 1'b1, 4, 16'h00BB, 1'b0));
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b0, 3, 16'h00BB, 1'b0));
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b0, 2, 16'h00BB, 1'b0));
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1, 16'h00BB, 1'b0));
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h00BB, 1'b0));
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
